// File: rtl/rv_uart_tx_device.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores feed a small byte FIFO,
// STATUS reports busy/full/overflow/occupancy on the same data bus.
module rv_uart_tx_device #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] BASE_ADDR    = 32'h0000_1000,
    parameter int              CLKS_PER_BIT = 434,
    parameter int              FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [XLEN/8-1:0] data_be_i,
    input  logic [XLEN-1:0]   data_addr_i,
    input  logic [XLEN-1:0]   data_wdata_i,
    output logic              data_rvalid_o,
    output logic [XLEN-1:0]   data_rdata_o,
    output logic              tx_o
);

    localparam int              AW          = $clog2(FIFO_DEPTH);
    localparam int              CW          = AW + 1;
    localparam int              BW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]   BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_FULL    = CW'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] STATUS_ADDR = BASE_ADDR + XLEN'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e            state_q, state_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              rvalid_q, rvalid_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];

    logic              hit_tx, hit_st, hit;
    logic              push_req, push, pop, ovf_set;
    logic              fifo_full, fifo_empty, busy, baud_done;
    logic [XLEN-1:0]   status_word;
    logic              unused_bits;

    assign unused_bits = ^{data_be_i[XLEN/8-1:1], data_wdata_i[XLEN-1:8]};

    // Bus decode, FIFO bookkeeping and response generation
    always_comb begin
        hit_tx     = data_req_i && (data_addr_i == BASE_ADDR);
        hit_st     = data_req_i && (data_addr_i == STATUS_ADDR);
        hit        = hit_tx || hit_st;
        fifo_full  = (count_q == CNT_FULL);
        fifo_empty = (count_q == '0);
        push_req   = hit_tx && data_we_i && data_be_i[0];
        push       = push_req && !fifo_full;
        ovf_set    = push_req && fifo_full;
        busy       = (state_q != S_IDLE) || !fifo_empty;

        status_word      = '0;
        status_word[0]   = busy;
        status_word[1]   = fifo_full;
        status_word[2]   = ovf_q;
        status_word[5:3] = 3'(count_q);

        rvalid_d = hit;
        rdata_d  = (hit_st && !data_we_i) ? status_word : '0;

        // A fresh overflow outranks the read-to-clear
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (hit_st && !data_we_i) begin
            ovf_d = 1'b0;
        end
    end

    // Serializer FSM; tx is registered so the line lags the state by one cycle
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + BW'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        tx_d      = 1'b1;
        pop       = 1'b0;
        baud_done = (baud_q == BAUD_LAST);

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (baud_done) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pop) begin
            shift_d = mem_q[rptr_q];
        end
    end

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            mem_d[wptr_q] = data_wdata_i[7:0];
            wptr_d        = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b1;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Payload storage carries no reset; the pointers and count define validity
    always_ff @(posedge clk) begin
        mem_q   <= mem_d;
        shift_q <= shift_d;
    end

    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign tx_o          = tx_q;

endmodule

// File: tb/tb_rv_uart_tx_device.sv
// Bench for rv_uart_tx_device: bus transactions against a spec-level model of
// acceptance, status words and 8N1 line waveforms, plus a line decoder.
module tb_rv_uart_tx_device;

    localparam int          CPB     = 4;
    localparam logic [31:0] BASE    = 32'h0000_1000;
    localparam logic [31:0] ST_ADDR = BASE + 32'd4;

    typedef logic [7:0] byte_q_t[$];

    logic        clk;
    logic        arstn;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        tx_o;

    int      n_checks = 0;
    int      n_pass   = 0;
    bit      mon_en   = 1'b0;
    byte_q_t rx_q;

    rv_uart_tx_device #(
        .XLEN(32), .BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .arstn(arstn),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .tx_o(tx_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Status word as the register map defines it
    function automatic logic [31:0] st_word(bit busy, bit full, bit ovf, int cnt);
        return 32'(busy) | (32'(full) << 1) | (32'(ovf) << 2) | (32'(cnt) << 3);
    endfunction

    // Line level of bit slot k (0..9) of an 8N1 frame carrying b
    function automatic logic frame_bit(logic [7:0] b, int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    // Independent line receiver: samples mid-bit, records decoded bytes
    always begin : line_monitor
        logic [7:0] b;
        @(negedge tx_o);
        if (mon_en && arstn) begin
            repeat (CPB/2) @(negedge clk);
            n_checks++;
            if (tx_o !== 1'b0) $display("FAIL mon_start: tx=%b required 0", tx_o);
            else n_pass++;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = tx_o;
            end
            repeat (CPB) @(negedge clk);
            if (mon_en) begin
                n_checks++;
                if (tx_o !== 1'b1) $display("FAIL mon_stop: tx=%b required 1", tx_o);
                else n_pass++;
                rx_q.push_back(b);
            end
        end
    end

    task automatic idle_bus();
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
    endtask

    // Called at a falling edge; returns at the next falling edge, where the response is visible
    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be);
        data_req_i   = 1'b1;
        data_we_i    = we;
        data_addr_i  = addr;
        data_wdata_i = wd;
        data_be_i    = be;
        @(negedge clk);
    endtask

    task automatic read_status(output logic [31:0] v, output logic vld);
        drive(1'b0, ST_ADDR, 32'h0, 4'hF);
        vld = data_rvalid_o;
        v   = data_rdata_o;
        idle_bus();
    endtask

    task automatic wait_idle(output bit ok, output logic [31:0] v);
        logic vld;
        ok = 1'b0;
        v  = 'x;
        for (int i = 0; i < 3000; i++) begin
            read_status(v, vld);
            if (vld === 1'b1 && v[0] === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Compares tx_o every cycle against the contiguous frames of the given bytes
    task automatic expect_wave(input byte_q_t bytes, input string name);
        logic exp;
        for (int j = 0; j < bytes.size(); j++) begin
            for (int k = 0; k < 10; k++) begin
                exp = frame_bit(bytes[j], k);
                for (int c = 0; c < CPB; c++) begin
                    n_checks++;
                    if (tx_o !== exp)
                        $display("FAIL %s byte%0d slot%0d cyc%0d: tx=%b required %b",
                                 name, j, k, c, tx_o, exp);
                    else n_pass++;
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        idle_bus();
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx_o !== 1'b1 || data_rvalid_o !== 1'b0 || data_rdata_o !== 32'h0)
            $display("FAIL reset_outputs: tx=%b rvalid=%b rdata=%h required 1/0/0",
                     tx_o, data_rvalid_o, data_rdata_o);
        else n_pass++;
        arstn = 1'b1;
        @(negedge clk);
        begin
            logic [31:0] v; logic vld;
            read_status(v, vld);
            n_checks++;
            if (vld !== 1'b1 || v !== 32'h0)
                $display("FAIL reset_status: rvalid=%b status=%h required 1/00000000", vld, v);
            else n_pass++;
        end
    endtask

    task automatic test_single_byte();
        logic [31:0] v; logic vld;
        byte_q_t exp_q;
        exp_q = '{8'hA5};
        rx_q.delete();
        drive(1'b1, BASE, 32'hFFFF_FFA5, 4'h1);
        n_checks++;
        if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h0)
            $display("FAIL single_wr_resp: rvalid=%b rdata=%h required 1/0", data_rvalid_o, data_rdata_o);
        else n_pass++;
        read_status(v, vld);
        n_checks++;
        if (vld !== 1'b1 || v !== st_word(1, 0, 0, 1))
            $display("FAIL single_busy_early: status=%h required %h", v, st_word(1, 0, 0, 1));
        else n_pass++;
        n_checks++;
        if (tx_o !== 1'b1) $display("FAIL single_pre_start: tx=%b required 1", tx_o);
        else n_pass++;
        @(negedge clk);
        expect_wave(exp_q, "single_wave");
        n_checks++;
        if (tx_o !== 1'b1) $display("FAIL single_post_idle: tx=%b required 1", tx_o);
        else n_pass++;
        read_status(v, vld);
        n_checks++;
        if (vld !== 1'b1 || v !== 32'h0)
            $display("FAIL single_status_done: status=%h required 00000000", v);
        else n_pass++;
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5)
            $display("FAIL single_rx: got %0d bytes first=%h required 1 byte a5",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00);
        else n_pass++;
    endtask

    task automatic check_rx(input byte_q_t exp_q, input string name);
        n_checks++;
        if (rx_q.size() != exp_q.size()) begin
            $display("FAIL %s_len: received %0d bytes required %0d", name, rx_q.size(), exp_q.size());
        end else begin
            bit same = 1'b1;
            for (int i = 0; i < exp_q.size(); i++)
                if (rx_q[i] !== exp_q[i]) same = 1'b0;
            if (!same) $display("FAIL %s_data: received %p required %p", name, rx_q, exp_q);
            else n_pass++;
        end
    endtask

    task automatic test_queue_overflow();
        logic [31:0] v; logic vld; bit ok;
        byte_q_t exp_q;
        rx_q.delete();
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, BASE, 32'(i), 4'h1);
            n_checks++;
            if (data_rvalid_o !== 1'b1) $display("FAIL queue_wr_rvalid%0d: rvalid=%b required 1", i, data_rvalid_o);
            else n_pass++;
            if (i <= 5) exp_q.push_back(8'(i));
        end
        read_status(v, vld);
        n_checks++;
        if (v !== st_word(1, 1, 1, 4)) $display("FAIL queue_status_ovf: status=%h required %h", v, st_word(1, 1, 1, 4));
        else n_pass++;
        read_status(v, vld);
        n_checks++;
        if (v !== st_word(1, 1, 0, 4)) $display("FAIL queue_ovf_cleared: status=%h required %h", v, st_word(1, 1, 0, 4));
        else n_pass++;
        wait_idle(ok, v);
        n_checks++;
        if (!ok || v !== 32'h0) $display("FAIL queue_drain: ok=%b status=%h required 1/00000000", ok, v);
        else n_pass++;
        check_rx(exp_q, "queue_rx");
    endtask

    task automatic test_contiguity();
        logic [31:0] v; logic vld;
        byte_q_t exp_q;
        rx_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(8'($urandom));
        for (int i = 0; i < 3; i++) drive(1'b1, BASE, {24'h0, exp_q[i]}, 4'hF);
        idle_bus();
        expect_wave(exp_q, "contig_wave");
        n_checks++;
        if (tx_o !== 1'b1) $display("FAIL contig_end_idle: tx=%b required 1", tx_o);
        else n_pass++;
        read_status(v, vld);
        n_checks++;
        if (v !== 32'h0) $display("FAIL contig_status: status=%h required 00000000", v);
        else n_pass++;
        check_rx(exp_q, "contig_rx");
    endtask

    task automatic test_nonhit_be();
        logic [31:0] v; logic vld; bit line_ok;
        drive(1'b0, BASE + 32'd8, 32'h0, 4'hF);
        n_checks++;
        if (data_rvalid_o !== 1'b0 || data_rdata_o !== 32'h0)
            $display("FAIL nonhit_rd: rvalid=%b rdata=%h required 0/0", data_rvalid_o, data_rdata_o);
        else n_pass++;
        drive(1'b1, BASE + 32'd8, 32'h55, 4'hF);
        n_checks++;
        if (data_rvalid_o !== 1'b0) $display("FAIL nonhit_wr: rvalid=%b required 0", data_rvalid_o);
        else n_pass++;
        drive(1'b1, BASE, 32'h66, 4'b0010);
        n_checks++;
        if (data_rvalid_o !== 1'b1) $display("FAIL be_wr_resp: rvalid=%b required 1", data_rvalid_o);
        else n_pass++;
        drive(1'b0, BASE, 32'h0, 4'hF);
        n_checks++;
        if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h0)
            $display("FAIL txdata_rd: rvalid=%b rdata=%h required 1/0", data_rvalid_o, data_rdata_o);
        else n_pass++;
        drive(1'b1, ST_ADDR, 32'hFFFF_FFFF, 4'hF);
        n_checks++;
        if (data_rvalid_o !== 1'b1) $display("FAIL status_wr_resp: rvalid=%b required 1", data_rvalid_o);
        else n_pass++;
        idle_bus();
        @(negedge clk);
        n_checks++;
        if (data_rvalid_o !== 1'b0 || data_rdata_o !== 32'h0)
            $display("FAIL no_req_quiet: rvalid=%b rdata=%h required 0/0", data_rvalid_o, data_rdata_o);
        else n_pass++;
        read_status(v, vld);
        n_checks++;
        if (vld !== 1'b1 || v !== 32'h0) $display("FAIL nonhit_count: status=%h required 00000000", v);
        else n_pass++;
        line_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (tx_o !== 1'b1) line_ok = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (!line_ok) $display("FAIL nonhit_line: tx left idle, required constant 1");
        else n_pass++;
    endtask

    task automatic test_ovf_ordering();
        logic [31:0] v; logic vld; bit ok;
        byte_q_t exp_q;
        rx_q.delete();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'($urandom));
            drive(1'b1, BASE, {24'h0, exp_q[i]}, 4'h1);
        end
        read_status(v, vld);
        n_checks++;
        if (v !== st_word(1, 1, 0, 4)) $display("FAIL ord_before: status=%h required %h", v, st_word(1, 1, 0, 4));
        else n_pass++;
        drive(1'b1, BASE, 32'hEE, 4'h1);
        read_status(v, vld);
        n_checks++;
        if (v !== st_word(1, 1, 1, 4)) $display("FAIL ord_set: status=%h required %h", v, st_word(1, 1, 1, 4));
        else n_pass++;
        drive(1'b1, BASE, 32'hEF, 4'h1);
        read_status(v, vld);
        n_checks++;
        if (v[2] !== 1'b1) $display("FAIL ord_reset_after_clear: ovf=%b required 1", v[2]);
        else n_pass++;
        read_status(v, vld);
        n_checks++;
        if (v[2] !== 1'b0) $display("FAIL ord_cleared: ovf=%b required 0", v[2]);
        else n_pass++;
        wait_idle(ok, v);
        n_checks++;
        if (!ok) $display("FAIL ord_drain: device never went idle");
        else n_pass++;
        check_rx(exp_q, "ord_rx");
    endtask

    task automatic test_random();
        logic [31:0] v; logic vld; bit ok;
        for (int it = 0; it < 6; it++) begin
            byte_q_t exp_q;
            int      k, acc;
            logic [7:0] b;
            rx_q.delete();
            k = $urandom_range(1, 7);
            for (int i = 0; i < k; i++) begin
                b = 8'($urandom);
                drive(1'b1, BASE, {24'($urandom), b}, {3'($urandom), 1'b1});
                if (i < 5) exp_q.push_back(b);
                case ($urandom_range(0, 4))
                    0: drive(1'b0, BASE + 32'd12, 32'h0, 4'hF);
                    1: drive(1'b1, BASE, 32'($urandom), 4'b1110);
                    2: drive(1'b1, ST_ADDR, 32'($urandom), 4'hF);
                    3: drive(1'b0, BASE, 32'h0, 4'hF);
                    default: ;
                endcase
            end
            acc = exp_q.size();
            read_status(v, vld);
            n_checks++;
            if (v !== st_word(1, acc == 5, k > 5, acc - 1))
                $display("FAIL rand%0d_status: k=%0d status=%h required %h",
                         it, k, v, st_word(1, acc == 5, k > 5, acc - 1));
            else n_pass++;
            wait_idle(ok, v);
            n_checks++;
            if (!ok || v !== 32'h0) $display("FAIL rand%0d_drain: ok=%b status=%h required 1/0", it, ok, v);
            else n_pass++;
            check_rx(exp_q, $sformatf("rand%0d_rx", it));
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] v; logic vld; bit line_ok;
        mon_en = 1'b0;
        drive(1'b1, BASE, 32'h00, 4'h1);
        drive(1'b1, BASE, 32'h00, 4'h1);
        idle_bus();
        repeat (15) @(negedge clk);
        n_checks++;
        if (tx_o !== 1'b0) $display("FAIL mid_line_low: tx=%b required 0", tx_o);
        else n_pass++;
        data_req_i  = 1'b1;
        data_addr_i = ST_ADDR;
        @(posedge clk);
        #1;
        n_checks++;
        if (data_rvalid_o !== 1'b1) $display("FAIL mid_pre_rvalid: rvalid=%b required 1", data_rvalid_o);
        else n_pass++;
        arstn = 1'b0;
        #1;
        n_checks++;
        if (tx_o !== 1'b1 || data_rvalid_o !== 1'b0 || data_rdata_o !== 32'h0)
            $display("FAIL mid_async_reset: tx=%b rvalid=%b rdata=%h required 1/0/0",
                     tx_o, data_rvalid_o, data_rdata_o);
        else n_pass++;
        idle_bus();
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        read_status(v, vld);
        n_checks++;
        if (vld !== 1'b1 || v !== 32'h0) $display("FAIL mid_status_after: status=%h required 00000000", v);
        else n_pass++;
        line_ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (tx_o !== 1'b1) line_ok = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (!line_ok) $display("FAIL mid_fifo_discarded: line left idle after reset");
        else n_pass++;
    endtask

    initial begin
        arstn = 1'b0;
        idle_bus();
        @(negedge clk);
        test_reset();
        mon_en = 1'b1;
        test_single_byte();
        test_queue_overflow();
        test_contiguity();
        test_nonhit_be();
        test_ovf_ordering();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
